instr_memory: RTL and testbench
===============================

INSTR_MEMORY -- requirements
Module: instr_memory

Interface
REQ-001 SHALL provide parameter DEPTH_BYTES, default 1024, memory size in bytes (power of two, multiple of WORD_BYTES).
REQ-002 SHALL provide parameter WORD_BYTES, default 4, bytes per fetched word (power of two, >=1).
REQ-003 SHALL provide parameter LATENCY, default 3, clock edges from accepted request to data (>=1).
REQ-004 SHALL derive ADDR_W = clog2(DEPTH_BYTES) and DATA_W = 8*WORD_BYTES, not user-set.
REQ-005 CLK  input  1  single clock; all state updates on rising edge.
REQ-006 RESET  input  1  synchronous, active-high reset.
REQ-007 READ  input  1  fetch request, level-sensitive.
REQ-008 ADDRESS  input  ADDR_W  byte address of word (PC).
REQ-009 READDATA  output  DATA_W  fetched word, registered.
REQ-010 BUSYWAIT  output  1  registered; high while a fetch is in progress.
REQ-011 VALID  output  1  one-cycle pulse: READDATA updated this cycle.
REQ-012 ERROR  output  1  one-cycle pulse: misaligned request rejected.
REQ-013 LOAD_EN  input  1  byte-write enable for program loading.
REQ-014 LOAD_ADDR  input  ADDR_W  byte address to write.
REQ-015 LOAD_DATA  input  8  byte to write.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, DONE plus a down-counter of width clog2(LATENCY)+1.
REQ-017 IDLE: READ=1 and ADDRESS aligned (low clog2(WORD_BYTES) bits zero) at edge k -> latch ADDRESS, BUSYWAIT=1, counter=LATENCY-1, go WAIT.
REQ-018 IDLE: READ=1 and ADDRESS misaligned -> ERROR=1 for one cycle, stay IDLE, BUSYWAIT=0, READDATA unchanged.
REQ-019 WAIT: counter!=0 -> decrement; counter==0 -> load READDATA, BUSYWAIT=0, VALID=1, go DONE; data thus appears at edge k+LATENCY (LATENCY=1: WAIT lasts one cycle).
REQ-020 READDATA SHALL be little-endian: byte at latched address in bits [7:0], address+i in bits [8i+7:8i].
REQ-021 ADDRESS/READ changes during WAIT SHALL be ignored; the latched address is used.
REQ-022 DONE: READ=1 with aligned ADDRESS -> start a new fetch as in REQ-017 (back-to-back, no IDLE cycle); misaligned -> ERROR pulse, go IDLE; READ=0 -> go IDLE.
REQ-023 VALID and ERROR SHALL never be high in the same cycle.
REQ-024 LOAD_EN=1 SHALL write LOAD_DATA to byte LOAD_ADDR at the edge, in any state, independent of READ.
REQ-025 Word assembly at the completion edge SHALL use pre-edge memory contents (read-before-write) when a load hits the same byte on that edge; loads on earlier edges SHALL be visible.
REQ-026 Aligned addressing SHALL never straddle the end of memory; no wrap logic beyond ADDR_W truncation.

Reset
REQ-027 RESET=1 at an edge SHALL force IDLE, counter=0, READDATA=0, BUSYWAIT=0, VALID=0, ERROR=0, overriding READ.
REQ-028 RESET mid-WAIT SHALL abort the fetch with no VALID pulse and READDATA=0.
REQ-029 RESET SHALL NOT clear memory contents; LOAD_EN writes SHALL still occur while RESET=1.

Verification
REQ-030 Load bytes 0x05,0x00,0x04,0x00 at 0..3; READ=1 ADDRESS=0 at edge k, LATENCY=3 -> BUSYWAIT high edges k..k+2, READDATA=0x00040005 and VALID at k+3.
REQ-031 READ held high, ADDRESS 0 then 4 -> second fetch accepted at DONE edge, second VALID exactly LATENCY+1 edges after the first.
REQ-032 READ=1 ADDRESS=0x002 -> ERROR one cycle, BUSYWAIT stays 0, READDATA unchanged.
REQ-033 RESET asserted one edge after fetch start -> BUSYWAIT=0, READDATA=0, no VALID; subsequent fetch of same address returns stored word.
REQ-034 LOAD byte 3 = 0xAB on completion edge of fetch at 0 -> READDATA old byte 0x00; refetch -> 0xAB040005.
REQ-035 Parameter sweep LATENCY=1, WORD_BYTES=8, DEPTH_BYTES=64 -> fetch at address 56 returns bytes 56..63 one edge after request.

Source files
------------

// File: rtl/instr_memory.sv
// Byte-addressed instruction memory with a fixed-latency, word-wide fetch port
// and a separate byte-wide load port for program loading.
module instr_memory #(
  parameter int DEPTH_BYTES = 1024,
  parameter int WORD_BYTES  = 4,
  parameter int LATENCY     = 3,
  localparam int ADDR_W     = $clog2(DEPTH_BYTES),
  localparam int DATA_W     = 8 * WORD_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] readdata,
  output logic              busywait,
  output logic              valid,
  output logic              error,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data
);

  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0]  CNT_INIT   = CNT_W'(LATENCY - 1);
  // Low address bits that must be zero for a word-aligned fetch; an all-zero
  // mask when WORD_BYTES is 1 avoids a zero-width slice.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  logic [7:0] mem [DEPTH_BYTES];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;
  logic [DATA_W-1:0] fetch_word;
  logic              aligned;

  assign aligned  = (address & ALIGN_MASK) == '0;
  assign readdata = data_q;
  assign busywait = busy_q;
  assign valid    = valid_q;
  assign error    = error_q;

  // Program-load port: one byte per edge, in any state, even during reset.
  // NOTE: the storage array has no reset branch, so it maps onto plain RAM and
  // keeps the loaded program across a reset.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  // Little-endian word assembly from the latched address; reads the array
  // before any same-edge load lands, giving read-before-write behaviour.
  always_comb begin
    fetch_word = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      fetch_word[8*i +: 8] = mem[addr_q + ADDR_W'(i)];
    end
  end

  // Next-state and next-output logic for the fetch sequencer.
  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (read) begin
          if (aligned) begin
            addr_d  = address;
            busy_d  = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = ST_WAIT;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // Inputs are ignored here; the fetch runs off the latched address.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          data_d  = fetch_word;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any fetch in progress.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_instr_memory.sv
// Self-checking bench for instr_memory: a default instance (1 KiB, 4-byte
// words, latency 3) and a small instance (64 B, 8-byte words, latency 1),
// both checked against a byte-array reference model.
module tb_instr_memory;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;

  logic        read;
  logic [9:0]  address;
  logic [31:0] readdata;
  logic        busywait, valid, error;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [7:0]  load_data;

  logic        s_read;
  logic [5:0]  s_address;
  logic [63:0] s_readdata;
  logic        s_busywait, s_valid, s_error;
  logic        s_load_en;
  logic [5:0]  s_load_addr;
  logic [7:0]  s_load_data;

  logic [7:0]  ref_mem   [1024];
  logic [7:0]  ref_small [64];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_memory #(.DEPTH_BYTES(1024), .WORD_BYTES(4), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .read(read), .address(address),
    .readdata(readdata), .busywait(busywait), .valid(valid), .error(error),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  instr_memory #(.DEPTH_BYTES(64), .WORD_BYTES(8), .LATENCY(1)) dut_small (
    .clk(clk), .reset(reset), .read(s_read), .address(s_address),
    .readdata(s_readdata), .busywait(s_busywait), .valid(s_valid), .error(s_error),
    .load_en(s_load_en), .load_addr(s_load_addr), .load_data(s_load_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [9:0] addr);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[(int'(addr) + i) % 1024];
    return w;
  endfunction

  function automatic logic [63:0] ref_word_small(input logic [5:0] addr);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_small[(int'(addr) + i) % 64];
    return w;
  endfunction

  // One complete fetch on the default instance: request edge, LAT-1 busy
  // edges with junk on read/address, then the completion edge.
  task automatic run_fetch(input logic [9:0] addr, input bit keep, input logic [9:0] next,
                           input string tag);
    logic [31:0] exp;
    exp = ref_word(addr);
    read = 1'b1; address = addr;
    tick();
    check({tag, "_accept_busy"},  busywait, 1);
    check({tag, "_accept_valid"}, valid,    0);
    check({tag, "_accept_error"}, error,    0);
    for (int e = 1; e < LAT; e++) begin
      read = 1'($urandom); address = 10'($urandom);
      tick();
      check({tag, "_wait_busy"},  busywait, 1);
      check({tag, "_wait_valid"}, valid,    0);
    end
    read = keep; address = next;
    tick();
    check({tag, "_done_valid"}, valid,    1);
    check({tag, "_done_busy"},  busywait, 0);
    check({tag, "_done_error"}, error,    0);
    check({tag, "_done_data"},  readdata, exp);
  endtask

  initial begin
    logic [31:0] prev;
    logic [9:0]  a;
    logic [63:0] sexp;

    reset = 1'b1; read = 1'b0; address = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    s_read = 1'b0; s_address = '0;
    s_load_en = 1'b0; s_load_addr = '0; s_load_data = '0;

    // Program both memories while reset is held: loads must still land.
    for (int i = 0; i < 1024; i++) begin
      load_en = 1'b1; load_addr = 10'(i); load_data = 8'($urandom);
      ref_mem[i] = load_data;
      s_load_en = (i < 64); s_load_addr = 6'(i); s_load_data = 8'($urandom);
      if (i < 64) ref_small[i] = s_load_data;
      tick();
    end
    s_load_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_addr = 10'(i);
      load_data = (i == 0) ? 8'h05 : (i == 2) ? 8'h04 : 8'h00;
      ref_mem[i] = load_data;
      tick();
    end
    load_en = 1'b0;

    check("reset_readdata", readdata, 0);
    check("reset_busy",     busywait, 0);
    check("reset_valid",    valid,    0);
    check("reset_error",    error,    0);
    check("reset_s_data",   s_readdata, 0);
    check("reset_s_busy",   s_busywait, 0);

    reset = 1'b0;
    tick();

    // Basic fetch of the directed word at address 0.
    run_fetch(10'h000, 1'b0, 10'h000, "fetch0");
    check("fetch0_literal", readdata, 32'h0004_0005);
    tick();
    check("fetch0_valid_pulse", valid, 0);
    check("fetch0_hold_data",   readdata, 32'h0004_0005);

    // Back-to-back: second request accepted on the DONE edge.
    run_fetch(10'h000, 1'b1, 10'h004, "b2b_first");
    run_fetch(10'h004, 1'b0, 10'h000, "b2b_second");
    tick();

    // Misaligned request from IDLE.
    prev = readdata;
    read = 1'b1; address = 10'h002;
    tick();
    check("misalign_error", error,    1);
    check("misalign_busy",  busywait, 0);
    check("misalign_valid", valid,    0);
    check("misalign_data",  readdata, prev);
    read = 1'b0;
    tick();
    check("misalign_error_pulse", error, 0);

    // Misaligned request from DONE returns to IDLE.
    run_fetch(10'h008, 1'b1, 10'h00B, "done_misalign_fetch");
    prev = readdata;
    tick();
    check("done_misalign_error", error,    1);
    check("done_misalign_busy",  busywait, 0);
    check("done_misalign_data",  readdata, prev);
    read = 1'b0;
    tick();
    check("done_misalign_idle_busy",  busywait, 0);
    check("done_misalign_idle_error", error,    0);

    // Reset one edge after a fetch starts aborts it.
    read = 1'b1; address = 10'h000;
    tick();
    check("abort_started", busywait, 1);
    reset = 1'b1; read = 1'b0;
    tick();
    check("abort_busy", busywait, 0);
    check("abort_data", readdata, 0);
    check("abort_valid", valid, 0);
    reset = 1'b0;
    for (int e = 0; e < LAT + 1; e++) begin
      tick();
      check("abort_no_valid", valid, 0);
    end
    run_fetch(10'h000, 1'b0, 10'h000, "after_abort");
    tick();

    // Load hitting byte 3 on the completion edge: old byte is returned.
    read = 1'b1; address = 10'h000;
    tick();
    read = 1'b0;
    for (int e = 1; e < LAT; e++) tick();
    load_en = 1'b1; load_addr = 10'h003; load_data = 8'hAB;
    tick();
    load_en = 1'b0;
    check("rbw_valid", valid, 1);
    check("rbw_data",  readdata, 32'h0004_0005);
    ref_mem[3] = 8'hAB;
    run_fetch(10'h000, 1'b0, 10'h000, "rbw_refetch");
    check("rbw_refetch_literal", readdata, 32'hAB04_0005);

    // Randomized traffic: occasional loads, random aligned fetches, chaining.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        read = 1'b0;
        load_en = 1'b1; load_addr = 10'($urandom); load_data = 8'($urandom);
        ref_mem[load_addr] = load_data;
        tick();
        load_en = 1'b0;
      end
      a = 10'($urandom) & 10'h3FC;
      run_fetch(a, 1'b0, 10'h000, "rand_fetch");
    end
    run_fetch(10'h3FC, 1'b0, 10'h000, "top_word");
    tick();

    // Small instance: 8-byte words, single-cycle wait.
    sexp = ref_word_small(6'd56);
    s_read = 1'b1; s_address = 6'd56;
    tick();
    check("small_accept_busy",  s_busywait, 1);
    check("small_accept_valid", s_valid,    0);
    s_address = 6'd8;
    tick();
    check("small_valid", s_valid,    1);
    check("small_busy",  s_busywait, 0);
    check("small_data",  s_readdata, sexp);
    sexp = ref_word_small(6'd8);
    tick();
    check("small_b2b_busy",  s_busywait, 1);
    check("small_b2b_valid", s_valid,    0);
    s_address = 6'd4;
    tick();
    check("small_b2b_valid2", s_valid,    1);
    check("small_b2b_data",   s_readdata, sexp);
    tick();
    check("small_misalign_error", s_error, 1);
    check("small_misalign_data",  s_readdata, sexp);
    s_read = 1'b0;
    tick();
    check("small_idle_error", s_error, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
